// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, instruction field positions, decode record.
// Latency: none (package only).
// Backpressure: not applicable.
package mips_pkg;

    // Opcodes handled by the decode stage
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Control produced by decode; wreg is 0 for anything that does not write
    typedef struct packed {
        logic [4:0] wreg;
        logic       wen;
        logic       mem_read;
        logic       mem_write;
        logic       rs_used;
        logic       rt_used;
    } decode_t;

    function automatic decode_t decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        decode_t d;
        d = '0;
        d.rs_used = 1'b1;
        case (op)
            OP_RTYPE: begin
                d.wreg    = rd;
                d.rt_used = 1'b1;
            end
            OP_LW: begin
                d.wreg     = rt;
                d.mem_read = 1'b1;
            end
            OP_SW: begin
                d.mem_write = 1'b1;
                d.rt_used   = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: d.wreg = rt;
            OP_BEQ:  d.rt_used = 1'b1;
            OP_J:    d.rs_used = 1'b0;     // rs bits are part of the jump target
            default: ;
        endcase
        // Register 0 is never a real destination
        d.wen = (d.wreg != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Hazard detection for the ID/EX boundary; ID_EX_FORWARD_EN selects load-use-only stalls.
// Latency: combinational.
// Backpressure: stall holds PC and IF/ID; flush or an invalid slot always releases it.
import mips_pkg::*;

module hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_wreg,
    output logic              stall
);

    logic rs_live;
    logic rt_live;
    logic hazard;

    // Register 0 is never a true source, so it can never create a hazard
    assign rs_live = rs_used && (rs != '0);
    assign rt_live = rt_used && (rt != '0);

`ifdef ID_EX_FORWARD_EN
    logic unused_mem;
    assign unused_mem = &{1'b0, mem_wen, mem_wreg};

    // Only a load in EX is unresolvable: its data appears one stage too late
    always_comb begin
        hazard = ex_valid && ex_mem_read && ex_wen &&
                 ((rs_live && (rs == ex_wreg)) || (rt_live && (rt == ex_wreg)));
    end
`else
    // Without bypass any in-flight write to a source must drain to the register file
    always_comb begin
        hazard = 1'b0;
        if (ex_valid && ex_wen &&
            ((rs_live && (rs == ex_wreg)) || (rt_live && (rt == ex_wreg))))
            hazard = 1'b1;
        if (ex_valid && ex_mem_read && ex_wen &&
            ((rs_live && (rs == ex_wreg)) || (rt_live && (rt == ex_wreg))))
            hazard = 1'b1;
        if (mem_wen &&
            ((rs_live && (rs == mem_wreg)) || (rt_live && (rt == mem_wreg))))
            hazard = 1'b1;
    end
`endif

    assign stall = id_valid && !flush && hazard;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: decode, operand select (MEM bypass when ID_EX_FORWARD_EN is defined), EX pipeline registers.
// Latency: one cycle from id_instr to ex_* outputs.
// Backpressure: id_stall holds IF/ID and a bubble enters EX; flush kills the entering instruction.
import mips_pkg::*;

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              flush,
    output logic [REG_AW-1:0] rf_read1,
    output logic [REG_AW-1:0] rf_read2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              mem_wen,
    input  logic [DATA_W-1:0] mem_result,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_shamt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              ex_wen,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    decode_t           dec;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              bubble;

    assign opcode = id_instr[OPC_MSB:OPC_LSB];
    assign rs     = id_instr[RS_MSB:RS_LSB];
    assign rt     = id_instr[RT_MSB:RT_LSB];
    assign rd     = id_instr[RD_MSB:RD_LSB];
    assign shamt  = id_instr[SH_MSB:SH_LSB];
    assign funct  = id_instr[FN_MSB:FN_LSB];
    assign imm16  = id_instr[IMM_MSB:IMM_LSB];
    assign dec    = decode(opcode, rt, rd);

    assign rf_read1 = rs;
    assign rf_read2 = rt;

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .id_valid    (id_valid),
        .flush       (flush),
        .rs          (rs),
        .rt          (rt),
        .rs_used     (dec.rs_used),
        .rt_used     (dec.rt_used),
        .ex_valid    (ex_valid),
        .ex_wen      (ex_wen),
        .ex_mem_read (ex_mem_read),
        .ex_wreg     (ex_wreg),
        .mem_wen     (mem_wen),
        .mem_wreg    (mem_wreg),
        .stall       (id_stall)
    );

`ifndef ID_EX_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = &{1'b0, mem_result};
`endif

    // Operand select; WB needs no bypass since the register file writes on the falling edge
    always_comb begin
        op1 = rf_data1;
        op2 = rf_data2;
`ifdef ID_EX_FORWARD_EN
        if (mem_wen && dec.rs_used && (rs != 5'd0) && (mem_wreg == rs))
            op1 = mem_result;
        if (mem_wen && dec.rt_used && (rt != 5'd0) && (mem_wreg == rt))
            op2 = mem_result;
`endif
    end

    assign bubble = !id_valid || flush || id_stall;

    // EX pipeline register; bubbles load all-zero so idle slots stay deterministic
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ex_valid     <= 1'b0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_imm       <= '0;
            ex_opcode    <= '0;
            ex_funct     <= '0;
            ex_shamt     <= '0;
            ex_wreg      <= '0;
            ex_wen       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_imm       <= '0;
            ex_opcode    <= '0;
            ex_funct     <= '0;
            ex_shamt     <= '0;
            ex_wreg      <= '0;
            ex_wen       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_op1       <= op1;
            ex_op2       <= op2;
            ex_imm       <= {{(DATA_W-16){imm16[15]}}, imm16};
            ex_opcode    <= opcode;
            ex_funct     <= funct;
            ex_shamt     <= shamt;
            ex_wreg      <= dec.wreg;
            ex_wen       <= dec.wen;
            ex_mem_read  <= dec.mem_read;
            ex_mem_write <= dec.mem_write;
        end
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, datapath width.
REQ-002 Parameter REG_AW, 5, register-address width.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  id_instr holds a valid instruction.
REQ-006 id_instr  input  32  instruction from IF/ID.
REQ-007 flush  input  1  taken branch/jump; kill instruction entering EX.
REQ-008 rf_read1 / rf_read2  output  5 each  combinational id_instr[25:21] / [20:16] to register-file read ports.
REQ-009 rf_data1 / rf_data2  input  32 each  register-file read data.
REQ-010 mem_wreg  input  5, mem_wen  input  1, mem_result  input  32  EX/MEM destination, write enable, result.
REQ-011 id_stall  output  1  hold PC and IF/ID this cycle.
REQ-012 ex_valid  output  1; ex_op1, ex_op2  output  32; ex_imm  output  32 sign-extended; ex_opcode  output  6; ex_funct  output  6; ex_shamt  output  5; ex_wreg  output  5; ex_wen, ex_mem_read, ex_mem_write  output  1 each.

Function
REQ-013 Latency one cycle: posedge captures decoded id_instr and operands into ex_* registers.
REQ-014 Decode: opcode 0x00 -> wreg=rd, wen=1; 0x23 (lw) -> wreg=rt, wen=1, mem_read=1; 0x2B (sw) -> mem_write=1; 0x08/0x0A/0x0C/0x0D -> wreg=rt, wen=1; 0x04 (beq), 0x02 (j), others -> no write, no memory.
REQ-015 wreg==0 forces wen=0; register 0 never forwarded nor causes a hazard.
REQ-016 rt is a source only for opcodes 0x00, 0x2B, 0x04.
REQ-017 Forwarding: operand = mem_result when mem_wen and mem_wreg equals source and source!=0, else rf_data; no WB forwarding (register file writes on negedge, visible before capture).
REQ-018 Load-use: ex_valid & ex_mem_read & ex_wreg!=0 & ex_wreg matches an active source of valid id_instr -> id_stall=1, bubble captured (ex_valid=0, ex_wen=ex_mem_read=ex_mem_write=0).
REQ-019 Stall lasts exactly one cycle for a single load-use; next cycle forwards from MEM.
REQ-020 flush captures a bubble next edge and forces id_stall=0, overriding stall.
REQ-021 id_valid=0 captures a bubble; id_stall=0.
REQ-022 ex_* data fields of a bubble are don't-care but deterministic (hold zero).

Reset
REQ-023 Rst low asynchronously clears every ex_* output to 0; id_stall combinational, 0 while ex_valid=0.
REQ-024 Rst asserted mid-stall discards the held instruction; first post-reset capture is a normal decode.

Configuration
REQ-025 Macro ID_EX_FORWARD_EN defined: forwarding per REQ-017, stalls per REQ-018 only.
REQ-026 Undefined: operands always rf_data; id_stall also asserted on any source match with (ex_valid & ex_wen & ex_wreg) or (mem_wen & mem_wreg), bubble inserted until clear.

Structure
REQ-027 Opcode/funct constants and field positions live in shared package mips_pkg.
REQ-028 Hazard/stall detection in sub-module hazard_unit; forwarding muxes and pipeline registers in id_ex_stage.

Verification
REQ-029 Reset: Rst=0 mid-run -> all ex_* 0 immediately, id_stall=0.
REQ-030 add $3,$1,$2 (rf 1,2) -> next cycle ex_op1=1, ex_op2=2, ex_wreg=3, ex_wen=1.
REQ-031 mem_wreg=1, mem_wen=1, mem_result=0x55, add $4,$1,$2 -> ex_op1=0x55 with ID_EX_FORWARD_EN; without, id_stall=1 then ex_op1 from rf.
REQ-032 lw $5,0($1) then add $6,$5,$2 -> one cycle id_stall=1 with bubble, then add issues with ex_op1 from mem_result.
REQ-033 Load-use stall plus flush same cycle -> bubble, id_stall=0.
REQ-034 addi $0,$1,7 -> ex_wen=0; following use of $0 causes no stall/forward.
